// File: rtl/sequencer_lut_loader_if.sv
// Host-side LUT entry stream: valid/ready handshake carrying one LUT command entry.
// The host drives the master modport; the loader receives on the slave modport.
interface sequencer_lut_loader_if #(
    parameter int unsigned ENTRY_WIDTH = 37
);
    logic                   entry_valid;
    logic [ENTRY_WIDTH-1:0] entry_data;
    logic                   entry_ready;

    modport master (
        output entry_valid,
        output entry_data,
        input  entry_ready
    );

    modport slave (
        input  entry_valid,
        input  entry_data,
        output entry_ready
    );
endinterface

// File: rtl/sequencer_lut_loader.sv
// Loads host LUT entries into the sequencer through its RST-state write port, reads them
// back for a checksum verify, and releases the sequencer with config_done_o on success.
module sequencer_lut_loader #(
    parameter int unsigned LUT_DEPTH      = 256,
    parameter int unsigned ENTRY_WIDTH    = 37,
    parameter int unsigned READBACK_WIDTH = 29,
    parameter int unsigned REWIND_CYCLES  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n_i,
    input  logic                      start_i,
    input  logic [8:0]                num_entries_i,
    sequencer_lut_loader_if.slave     host,
    output logic                      seq_reset_o,
    output logic                      lut_wen_o,
    output logic [ENTRY_WIDTH-1:0]    lut_write_data_o,
    output logic                      lut_rden_o,
    input  logic [READBACK_WIDTH-1:0] lut_read_data_i,
    output logic                      config_done_o,
    output logic                      busy_o,
    output logic                      error_o,
    output logic [1:0]                error_code_o,
    output logic [8:0]                entries_written_o
);

    localparam int unsigned RW = (REWIND_CYCLES > 1) ? $clog2(REWIND_CYCLES) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_REWIND = 3'd3;
    localparam logic [2:0] S_READ   = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_COUNT    = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;

    logic [2:0]             state_q, state_d;
    logic [8:0]             n_q, n_d;
    logic [8:0]             wcnt_q, wcnt_d;
    logic [8:0]             rissue_q, rissue_d;
    logic [8:0]             rcap_q, rcap_d;
    logic [RW-1:0]          rw_q, rw_d;
    logic [31:0]            wsum_q, wsum_d;
    logic [31:0]            rsum_q, rsum_d;
    logic                   ready_q, ready_d;
    logic                   wen_q, wen_d;
    logic [ENTRY_WIDTH-1:0] wdata_q, wdata_d;
    logic                   rden_q, rden_d;
    logic                   rvalid_q, rvalid_d;
    logic                   seq_reset_q, seq_reset_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [1:0]             ecode_q, ecode_d;
    logic                   busy_q, busy_d;

    logic accept;
    logic count_ok;

    assign accept   = ready_q & host.entry_valid;
    assign count_ok = (num_entries_i != 9'd0) && (num_entries_i <= 9'(LUT_DEPTH));

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        wcnt_d      = wcnt_q;
        rissue_d    = rissue_q;
        rcap_d      = rcap_q;
        rw_d        = rw_q;
        wsum_d      = wsum_q;
        rsum_d      = rsum_q;
        ready_d     = 1'b0;
        wen_d       = 1'b0;
        wdata_d     = wdata_q;
        rden_d      = 1'b0;
        rvalid_d    = rden_q;
        seq_reset_d = 1'b0;
        done_d      = done_q;
        err_d       = err_q;
        ecode_d     = ecode_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    n_d     = num_entries_i;
                    wcnt_d  = '0;
                    wsum_d  = '0;
                    rsum_d  = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    ecode_d = ERR_NONE;
                    if (count_ok) begin
                        state_d     = S_CLR;
                        seq_reset_d = 1'b1;
                        rw_d        = '0;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        ecode_d = ERR_COUNT;
                    end
                end
            end

            // Both reset pulses share one counter; the pulse ends on the last count.
            S_CLR, S_REWIND: begin
                if (rw_q == RW'(REWIND_CYCLES - 1)) begin
                    if (state_q == S_CLR) begin
                        state_d = S_WRITE;
                        ready_d = (wcnt_q < n_q);
                    end else begin
                        state_d  = S_READ;
                        rden_d   = 1'b1;
                        rissue_d = 9'd1;
                        rcap_d   = '0;
                    end
                end else begin
                    rw_d        = rw_q + 1'b1;
                    seq_reset_d = 1'b1;
                end
            end

            S_WRITE: begin
                if (accept) begin
                    wen_d   = 1'b1;
                    wdata_d = host.entry_data;
                    wcnt_d  = wcnt_q + 1'b1;
                    wsum_d  = wsum_q + {{(32 - READBACK_WIDTH){1'b0}},
                                        host.entry_data[READBACK_WIDTH-1:0]};
                end
                ready_d = (wcnt_d < n_q);
                // The N-th pulse is on the wire this cycle, so the rewind may start next.
                if (wen_q && (wcnt_q == n_q)) begin
                    state_d     = S_REWIND;
                    ready_d     = 1'b0;
                    seq_reset_d = 1'b1;
                    rw_d        = '0;
                end
            end

            S_READ: begin
                if (rissue_q < n_q) begin
                    rden_d   = 1'b1;
                    rissue_d = rissue_q + 1'b1;
                end
                if (rvalid_q) begin
                    rsum_d = rsum_q + {{(32 - READBACK_WIDTH){1'b0}}, lut_read_data_i};
                    rcap_d = rcap_q + 1'b1;
                    if (rcap_q == (n_q - 9'd1)) begin
                        state_d = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                if (wsum_q == rsum_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                    ecode_d = ERR_CHECKSUM;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CLR) || (state_d == S_WRITE) || (state_d == S_REWIND) ||
                 (state_d == S_READ) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            wcnt_q      <= '0;
            rissue_q    <= '0;
            rcap_q      <= '0;
            rw_q        <= '0;
            wsum_q      <= '0;
            rsum_q      <= '0;
            ready_q     <= 1'b0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            rden_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            seq_reset_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ecode_q     <= ERR_NONE;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            wcnt_q      <= wcnt_d;
            rissue_q    <= rissue_d;
            rcap_q      <= rcap_d;
            rw_q        <= rw_d;
            wsum_q      <= wsum_d;
            rsum_q      <= rsum_d;
            ready_q     <= ready_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            rden_q      <= rden_d;
            rvalid_q    <= rvalid_d;
            seq_reset_q <= seq_reset_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ecode_q     <= ecode_d;
            busy_q      <= busy_d;
        end
    end

    assign host.entry_ready  = ready_q;
    assign seq_reset_o       = seq_reset_q;
    assign lut_wen_o         = wen_q;
    assign lut_write_data_o  = wdata_q;
    assign lut_rden_o        = rden_q;
    assign config_done_o     = done_q;
    assign busy_o            = busy_q;
    assign error_o           = err_q;
    assign error_code_o      = ecode_q;
    assign entries_written_o = wcnt_q;

endmodule

// File: tb/tb_sequencer_lut_loader.sv
// Directed bench for sequencer_lut_loader with a behavioural sequencer LUT attached;
// written entries are scoreboarded and load timing/outcome is checked per scenario.
module tb_sequencer_lut_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_i;
    logic [8:0]  num_entries_i;
    logic        seq_reset_o;
    logic        lut_wen_o;
    logic [36:0] lut_write_data_o;
    logic        lut_rden_o;
    logic [28:0] lut_read_data_i;
    logic        config_done_o;
    logic        busy_o;
    logic        error_o;
    logic [1:0]  error_code_o;
    logic [8:0]  entries_written_o;

    sequencer_lut_loader_if #(.ENTRY_WIDTH(37)) hif ();

    sequencer_lut_loader #(
        .LUT_DEPTH      (256),
        .ENTRY_WIDTH    (37),
        .READBACK_WIDTH (29),
        .REWIND_CYCLES  (2)
    ) dut (
        .clk               (clk),
        .reset_n_i         (reset_n),
        .start_i           (start_i),
        .num_entries_i     (num_entries_i),
        .host              (hif),
        .seq_reset_o       (seq_reset_o),
        .lut_wen_o         (lut_wen_o),
        .lut_write_data_o  (lut_write_data_o),
        .lut_rden_o        (lut_rden_o),
        .lut_read_data_i   (lut_read_data_i),
        .config_done_o     (config_done_o),
        .busy_o            (busy_o),
        .error_o           (error_o),
        .error_code_o      (error_code_o),
        .entries_written_o (entries_written_o)
    );

    always #5 clk = ~clk;

    // Sequencer LUT model: pointer cleared by its reset, read data one cycle after rden.
    logic [36:0] mem [256];
    logic [7:0]  ptr = 8'd0;
    int unsigned rd_idx = 0;
    logic        flip_en;
    logic [28:0] rdata = '0;

    always @(posedge clk) begin
        if (seq_reset_o) begin
            ptr    <= 8'd0;
            rd_idx <= 0;
        end else if (lut_wen_o) begin
            mem[ptr] <= lut_write_data_o;
            ptr      <= ptr + 8'd1;
        end else if (lut_rden_o) begin
            rdata  <= mem[ptr][28:0] ^ ((flip_en && rd_idx == 2) ? 29'd1 : 29'd0);
            ptr    <= ptr + 8'd1;
            rd_idx <= rd_idx + 1;
        end
    end
    assign lut_read_data_i = rdata;

    int checks = 0;
    int failures = 0;
    int cyc, wen_cnt, rden_cnt, srst_cnt, inv_viol, ready_viol;
    int wen_first, wen_last, rden_first, rden_last;
    logic [36:0] wq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; wen_cnt = 0; rden_cnt = 0; srst_cnt = 0; inv_viol = 0; ready_viol = 0;
        wen_first = -1; wen_last = -1; rden_first = -1; rden_last = -1;
    endtask

    task automatic tick();
        logic [36:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (lut_wen_o) begin
            wen_cnt++;
            if (wen_first < 0) wen_first = cyc;
            wen_last = cyc;
            if (wq.size() == 0) begin
                chk("wdata_unexpected", 64'd1, 64'd0);
            end else begin
                e = wq.pop_front();
                chk("wdata", lut_write_data_o, e);
            end
        end
        if (lut_rden_o) begin
            rden_cnt++;
            if (rden_first < 0) rden_first = cyc;
            rden_last = cyc;
        end
        if (seq_reset_o) srst_cnt++;
        if ((lut_wen_o && lut_rden_o) ||
            ((lut_wen_o || lut_rden_o) && (seq_reset_o || config_done_o))) inv_viol++;
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_seq_reset"}, seq_reset_o, 0);
        chk({pfx, "_wen"}, lut_wen_o, 0);
        chk({pfx, "_rden"}, lut_rden_o, 0);
        chk({pfx, "_done"}, config_done_o, 0);
        chk({pfx, "_busy"}, busy_o, 0);
        chk({pfx, "_error"}, error_o, 0);
        chk({pfx, "_ecode"}, error_code_o, 0);
        chk({pfx, "_written"}, entries_written_o, 0);
        chk({pfx, "_ready"}, hif.entry_ready, 0);
    endtask

    task automatic run_load(input int n, input bit gaps, input bit rnd, input int abort_at);
        int sent;
        int budget;
        logic [63:0] r64;
        logic [36:0] d;
        clear_mon();
        sent = 0;
        budget = 8 * n + 100;
        start_i = 1'b1;
        num_entries_i = 9'(n);
        tick();
        start_i = 1'b0;
        chk("start_seq_reset", seq_reset_o, 1);
        chk("start_busy", busy_o, 1);
        chk("start_done_clr", config_done_o, 0);
        chk("start_err_clr", error_o, 0);
        chk("start_written_clr", entries_written_o, 0);
        while (!config_done_o && !error_o && cyc < budget) begin
            if (abort_at > 0 && sent == abort_at) break;
            r64 = {$urandom(), $urandom()};
            d = rnd ? r64[36:0] : (37'h1_0000_0000 + 37'(sent + 1));
            hif.entry_valid = (sent < n) && (!gaps || $urandom_range(0, 1) == 1);
            hif.entry_data  = d;
            if (hif.entry_valid && hif.entry_ready) begin
                wq.push_back(d);
                sent++;
            end
            tick();
            if (sent == n && hif.entry_ready) ready_viol++;
        end
        hif.entry_valid = 1'b0;
        if (abort_at == 0) chk("load_finished", (config_done_o || error_o) ? 1 : 0, 1);
    endtask

    task automatic check_clean(input int n, input bit timing);
        chk("done", config_done_o, 1);
        chk("error", error_o, 0);
        chk("ecode", error_code_o, 0);
        chk("busy_end", busy_o, 0);
        chk("written", entries_written_o, n);
        chk("wen_count", wen_cnt, n);
        chk("rden_count", rden_cnt, n);
        chk("seq_reset_cycles", srst_cnt, 4);
        chk("scoreboard_empty", wq.size(), 0);
        chk("invariants", inv_viol, 0);
        chk("ready_after_last", ready_viol, 0);
        if (timing) begin
            chk("load_latency", cyc, 2 * n + 8);
            chk("wen_first", wen_first, 4);
            chk("wen_last", wen_last, n + 3);
            chk("rden_first", rden_first, n + 6);
            chk("rden_last", rden_last, 2 * n + 5);
        end
    endtask

    task automatic bad_count(input int n);
        clear_mon();
        start_i = 1'b1;
        num_entries_i = 9'(n);
        tick();
        start_i = 1'b0;
        chk("badcnt_error", error_o, 1);
        chk("badcnt_ecode", error_code_o, 1);
        chk("badcnt_busy", busy_o, 0);
        repeat (5) tick();
        chk("badcnt_no_seq_reset", srst_cnt, 0);
        chk("badcnt_no_wen", wen_cnt, 0);
        chk("badcnt_held", error_o, 1);
        chk("badcnt_done", config_done_o, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        start_i = 1'b0;
        num_entries_i = '0;
        flip_en = 1'b0;
        hif.entry_valid = 1'b0;
        hif.entry_data = '0;
        clear_mon();

        tick();
        check_all_zero("reset");
        // Start together with reset: reset must win.
        start_i = 1'b1;
        num_entries_i = 9'd4;
        tick();
        start_i = 1'b0;
        check_all_zero("reset_vs_start");
        reset_n = 1'b1;
        tick();

        run_load(4, 1'b0, 1'b0, 0);
        check_clean(4, 1'b1);

        run_load(2, 1'b0, 1'b1, 0);
        check_clean(2, 1'b1);

        flip_en = 1'b1;
        run_load(4, 1'b0, 1'b0, 0);
        flip_en = 1'b0;
        chk("flip_error", error_o, 1);
        chk("flip_ecode", error_code_o, 2);
        chk("flip_done", config_done_o, 0);
        chk("flip_wen_count", wen_cnt, 4);
        chk("flip_rden_count", rden_cnt, 4);
        chk("flip_latency", cyc, 16);
        repeat (3) tick();
        chk("flip_error_held", error_o, 1);
        chk("flip_done_held", config_done_o, 0);

        bad_count(0);
        bad_count(300);

        run_load(256, 1'b1, 1'b1, 0);
        check_clean(256, 1'b0);

        run_load(20, 1'b0, 1'b1, 10);
        reset_n = 1'b0;
        tick();
        check_all_zero("midload_reset");
        reset_n = 1'b1;
        wq.delete();
        run_load(20, 1'b0, 1'b1, 0);
        check_clean(20, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sequencer_lut_loader.md
# sequencer_lut_loader

Upstream configuration stage for the sequencer FSM. It accepts a stream of 37-bit LUT command entries from the host register interface and rewinds the sequencer's LUT address pointer. It writes the entries through the sequencer's RST-state write port, reads them back for a checksum verify, and then asserts config_done so the sequencer leaves RST and starts executing.

## Interface
- LUT_DEPTH, 256, maximum number of entries per load
- ENTRY_WIDTH, 37, LUT entry width: next_addr[36:29], sof[28], eof[27], data_length[26:11], repeat[10:3], next_state[2:0]
- READBACK_WIDTH, 29, width of the sequencer read-back port; bits [28:0] of the entry
- REWIND_CYCLES, 2, length of each seq_reset_o pulse

Ports:
- clk  in  1  system clock
- reset_n_i  in  1  synchronous, active-low reset
- start_i  in  1  single-cycle load request; ignored while busy_o=1
- num_entries_i  in  9  number of entries to load, legal range 1..256; sampled on an accepted start_i
- entry_valid_i  in  1  host entry valid
- entry_data_i  in  37  host entry data
- entry_ready_o  out  1  loader can accept an entry
- seq_reset_o  out  1  active-high reset to the sequencer (its reset_i)
- lut_wen_o  out  1  to sequencer lut_wen_i
- lut_write_data_o  out  37  to sequencer lut_write_data_i
- lut_rden_o  out  1  to sequencer lut_rden_i
- lut_read_data_i  in  29  from sequencer lut_read_data_o
- config_done_o  out  1  to sequencer config_done_i
- busy_o  out  1  load in progress
- error_o  out  1  load failed
- error_code_o  out  2  0 none, 1 bad count, 2 checksum mismatch
- entries_written_o  out  9  number of entries accepted in the current load

## Operation
- States: IDLE, CLR, WRITE, REWIND, READ, CHECK, DONE, ERROR.
- IDLE → CLR on start_i when num_entries_i is in 1..256. On start_i with num_entries_i=0 or >256: → ERROR, error_code_o=1.
- An accepted start_i in IDLE, DONE or ERROR does all of the following:
  - clears config_done_o, error_o, error_code_o, entries_written_o and both checksums;
  - latches N = num_entries_i.
- CLR: seq_reset_o=1 for REWIND_CYCLES, then → WRITE. This puts the sequencer in RST with its address pointer at 0.
- WRITE:
  - entry_ready_o = (entries_written_o < N).
  - On an accept (entry_valid_i & entry_ready_o): lut_wen_o=1 and lut_write_data_o=entry_data_i on the following cycle, for exactly one cycle.
  - On each accept: entries_written_o += 1 and wsum += zero-extend(entry_data_i[28:0]), mod 2^32.
  - Host stalls are unbounded; there is no timeout.
  - After the N-th write pulse has been issued → REWIND.
- REWIND: seq_reset_o=1 for REWIND_CYCLES, then → READ. This rewinds the sequencer address pointer to 0.
- READ:
  - lut_rden_o=1 on N consecutive cycles.
  - lut_read_data_i is valid exactly one cycle after each rden cycle; rsum accumulates it, mod 2^32.
  - After the N-th read data has been captured → CHECK.
- CHECK, one cycle:
  - wsum==rsum → DONE.
  - Otherwise → ERROR with error_code_o=2.
- DONE: config_done_o=1, held until the next accepted start_i or reset.
- ERROR: error_o=1, held until the next accepted start_i or reset. config_done_o stays 0.
- busy_o=1 in CLR, WRITE, REWIND, READ and CHECK.
- lut_wen_o and lut_rden_o are never high together, and never high while seq_reset_o=1 or config_done_o=1.

## Timing
- Reset value of every output is 0, including seq_reset_o, config_done_o, error_code_o and entries_written_o.
- When reset_n_i is sampled low, the loader returns to IDLE on that edge, from any state, including mid-WRITE or mid-READ. Partial loads are discarded.
- All outputs are registered.
- start_i → seq_reset_o=1 on the next cycle.
- Write throughput: one entry per cycle when entry_valid_i is held high.
- Minimum total load time for N entries with no stalls: 1 + REWIND_CYCLES + (N+1) + REWIND_CYCLES + (N+1) + 1 cycles, measured from start_i to config_done_o=1.
- Simultaneous start_i and reset: reset wins.
- Arithmetic: wsum and rsum are 32-bit, wrap-around allowed. Bits [36:29] (next_addr) are not verified, because the read port is 29 bits wide.
- N=256:
  - entries_written_o reaches 256 (9-bit counter).
  - The sequencer's 8-bit address wraps to 0 after the last write. REWIND still rewinds it explicitly.

## Test plan
- N=4, entries 0x1_0000_0001..0x1_0000_0004, valid held high, sequencer model attached → 4 back-to-back lut_wen_o pulses, then seq_reset_o for 2 cycles, then 4 lut_rden_o pulses. config_done_o=1 on the cycle after CHECK; error_o=0.
- N=4, model flips bit 0 of the 3rd read-back word → error_o=1, error_code_o=2, config_done_o stays 0.
- start_i with num_entries_i=0, and separately with num_entries_i=300 → ERROR on the next cycle, error_code_o=1, no seq_reset_o or lut_wen_o pulses.
- N=256 with random entry_valid_i gaps (50% duty) → exactly 256 write pulses, entries_written_o=256, entry_ready_o low after the 256th accept, config_done_o=1.
- reset_n_i low for 1 cycle after 10 of 20 writes → all outputs 0 on the next cycle. A subsequent start_i with N=20 completes a clean load with config_done_o=1.
- Restart from DONE with N=2 → config_done_o clears the cycle after start_i, followed by a full CLR/WRITE/REWIND/READ sequence.
